// File: rtl/fcvt_arb.sv
// Two-requester round-robin arbiter in front of a single float<->int converter.
// One operation in flight: grant in IDLE, convert in CONV, hold result in RESP.
module fcvt_arb #(
  parameter logic RESET_PRIO = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_a_i,
  input  logic        req0_signed_i,
  input  logic        req0_conv_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_a_i,
  input  logic        req1_signed_i,
  input  logic        req1_conv_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_id_o,
  output logic [1:0]  rsp_flags_o
);

  typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic [31:0] op_a_q, op_a_d;
  logic        op_signed_q, op_signed_d;
  logic        op_conv_q, op_conv_d;
  logic        op_id_q, op_id_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_id_q, rsp_id_d;
  logic [1:0]  rsp_flags_q, rsp_flags_d;
  logic        gnt0, gnt1;
  logic [33:0] conv_res;

  // Returns {nv, nx, result}; truncates toward zero and saturates out-of-range values.
  function automatic logic [33:0] f2i(input logic [31:0] a, input logic sgn);
    logic        neg, nv, nx, frac;
    logic [7:0]  e;
    logic [22:0] m;
    logic [54:0] wide;
    logic [31:0] mag, r;
    neg  = a[31];
    e    = a[30:23];
    m    = a[22:0];
    wide = {31'b0, 1'b1, m} << 5'(e - 8'd127);
    mag  = wide[54:23];
    frac = |wide[22:0];
    r    = 32'h0;
    nv   = 1'b0;
    nx   = 1'b0;
    if (e == 8'hFF && m != 23'h0) begin
      r  = sgn ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
      nv = 1'b1;
    end else if (e == 8'h00) begin
      nx = (m != 23'h0);
    end else if (e < 8'd127) begin
      nx = 1'b1;
    end else if (!sgn) begin
      if (neg) begin
        nv = 1'b1;
      end else if (e >= 8'd159) begin
        r  = 32'hFFFF_FFFF;
        nv = 1'b1;
      end else begin
        r  = mag;
        nx = frac;
      end
    end else if (!neg) begin
      if (e >= 8'd158) begin
        r  = 32'h7FFF_FFFF;
        nv = 1'b1;
      end else begin
        r  = mag;
        nx = frac;
      end
    end else if (e > 8'd158 || (e == 8'd158 && m != 23'h0)) begin
      r  = 32'h8000_0000;
      nv = 1'b1;
    end else begin
      // -2^31 lands here with mag = 0x80000000 and negates to itself
      r  = -mag;
      nx = frac;
    end
    return {nv, nx, r};
  endfunction

  // Returns {nv, nx, result}; round to nearest even, nv never set.
  function automatic logic [33:0] i2f(input logic [31:0] a, input logic sgn);
    logic        neg, g, st, up;
    logic [31:0] mag;
    logic [4:0]  lz;
    logic [30:0] norm, body;
    logic [22:0] mant;
    neg = sgn & a[31];
    mag = neg ? -a : a;
    lz  = 5'd0;
    for (int i = 0; i < 32; i++)
      if (mag[i]) lz = 5'(31 - i);
    norm = 31'(mag << lz);
    mant = norm[30:8];
    g    = norm[7];
    st   = |norm[6:0];
    up   = g & (st | mant[0]);
    // mantissa carry-out ripples into the exponent field
    body = {8'd158 - {3'b0, lz}, mant} + {30'b0, up};
    return {1'b0, g | st, (mag == 32'h0) ? 32'h0 : {neg, body}};
  endfunction

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && !rst_i) begin
      gnt0 = req0_valid_i && (!req1_valid_i || !prio_q);
      gnt1 = req1_valid_i && (!req0_valid_i ||  prio_q);
    end
  end

  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;
  assign conv_res     = op_conv_q ? i2f(op_a_q, op_signed_q) : f2i(op_a_q, op_signed_q);

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    op_a_d      = op_a_q;
    op_signed_d = op_signed_q;
    op_conv_d   = op_conv_q;
    op_id_d     = op_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_flags_d = rsp_flags_q;
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          op_a_d      = gnt1 ? req1_a_i      : req0_a_i;
          op_signed_d = gnt1 ? req1_signed_i : req0_signed_i;
          op_conv_d   = gnt1 ? req1_conv_i   : req0_conv_i;
          op_id_d     = gnt1;
          prio_d      = ~gnt1;
          state_d     = CONV;
        end
      end
      CONV: begin
        rsp_data_d  = conv_res[31:0];
        rsp_flags_d = conv_res[33:32];
        rsp_id_d    = op_id_q;
        state_d     = RESP;
      end
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      prio_q      <= RESET_PRIO;
      op_a_q      <= 32'h0;
      op_signed_q <= 1'b0;
      op_conv_q   <= 1'b0;
      op_id_q     <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_id_q    <= 1'b0;
      rsp_flags_q <= 2'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      op_a_q      <= op_a_d;
      op_signed_q <= op_signed_d;
      op_conv_q   <= op_conv_d;
      op_id_q     <= op_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_flags_o = rsp_flags_q;

endmodule

// File: tb/tb_fcvt_arb.sv
// Bench for fcvt_arb: vector table plus arbitration, backpressure and reset sequences,
// with responses checked against a queue of expected results filled at each grant.
module tb_fcvt_arb;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0, r0, r1;
  logic [31:0] a0 = 32'h0, a1 = 32'h0;
  logic        s0 = 1'b0, s1 = 1'b0, c0 = 1'b0, c1 = 1'b0;
  logic        rsp_valid, rsp_id;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_flags;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        id;
    logic [31:0] d;
    logic [1:0]  f;
  } exp_t;

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic        sgn;
    logic        conv;
    logic [31:0] d;
    logic [1:0]  f;
  } vec_t;

  exp_t        sb[$];
  logic [31:0] exp_d[2];
  logic [1:0]  exp_f[2];
  vec_t        vt[20];

  always #5 clk = ~clk;

  fcvt_arb dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req0_valid_i (v0),
    .req0_ready_o (r0),
    .req0_a_i     (a0),
    .req0_signed_i(s0),
    .req0_conv_i  (c0),
    .req1_valid_i (v1),
    .req1_ready_o (r1),
    .req1_a_i     (a1),
    .req1_signed_i(s1),
    .req1_conv_i  (c1),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_id_o     (rsp_id),
    .rsp_flags_o  (rsp_flags)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard: push at grant, pop at response handshake.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (v0 && r0) sb.push_back('{1'b0, exp_d[0], exp_f[0]});
      if (v1 && r1) sb.push_back('{1'b1, exp_d[1], exp_f[1]});
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) chk("sb_unexpected_rsp", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_data", rsp_data, e.d);
          chk("rsp_id", {31'b0, rsp_id}, {31'b0, e.id});
          chk("rsp_flags", {30'b0, rsp_flags}, {30'b0, e.f});
        end
      end
    end
  end

  task automatic set_req(input logic id, input logic [31:0] a, input logic sg, input logic cv,
                         input logic [31:0] d, input logic [1:0] f);
    exp_d[id] = d;
    exp_f[id] = f;
    if (id) begin a1 = a; s1 = sg; c1 = cv; v1 = 1'b1; end
    else    begin a0 = a; s0 = sg; c0 = cv; v0 = 1'b1; end
  endtask

  task automatic wait_grant(input logic id, input string nm);
    bit got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id ? r1 : r0) begin got = 1; break; end
    end
    if (!got) chk({nm, "_grant_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_drain(input string nm);
    bit done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (sb.size() == 0) begin done = 1; break; end
    end
    if (!done) chk({nm, "_drain_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_op(input vec_t v);
    @(posedge clk); #1;
    set_req(v.id, v.a, v.sgn, v.conv, v.d, v.f);
    wait_grant(v.id, "tbl");
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    wait_drain("tbl");
  endtask

  initial begin
    int n;
    logic [1:0] order;
    vt[0]  = '{1'b1, 32'hC048F5C3, 1'b1, 1'b0, 32'hFFFFFFFD, 2'b01};
    vt[1]  = '{1'b1, 32'hBF800000, 1'b0, 1'b0, 32'h00000000, 2'b10};
    vt[2]  = '{1'b1, 32'h7F800000, 1'b0, 1'b0, 32'hFFFFFFFF, 2'b10};
    vt[3]  = '{1'b0, 32'h00000064, 1'b0, 1'b1, 32'h42C80000, 2'b00};
    vt[4]  = '{1'b1, 32'hFFFFFF9C, 1'b1, 1'b1, 32'hC2C80000, 2'b00};
    vt[5]  = '{1'b0, 32'hFFFFFF9C, 1'b0, 1'b1, 32'h4F800000, 2'b01};
    vt[6]  = '{1'b1, 32'h00000001, 1'b0, 1'b1, 32'h3F800000, 2'b00};
    vt[7]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 2'b00};
    vt[8]  = '{1'b1, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 2'b01};
    vt[9]  = '{1'b0, 32'h4F000000, 1'b1, 1'b0, 32'h7FFFFFFF, 2'b10};
    vt[10] = '{1'b1, 32'hCF000000, 1'b1, 1'b0, 32'h80000000, 2'b00};
    vt[11] = '{1'b0, 32'hCF000001, 1'b1, 1'b0, 32'h80000000, 2'b10};
    vt[12] = '{1'b1, 32'h7FC00000, 1'b1, 1'b0, 32'h7FFFFFFF, 2'b10};
    vt[13] = '{1'b0, 32'hFF800000, 1'b1, 1'b0, 32'h80000000, 2'b10};
    vt[14] = '{1'b1, 32'h4F800000, 1'b0, 1'b0, 32'hFFFFFFFF, 2'b10};
    vt[15] = '{1'b0, 32'h4F7FFFFF, 1'b0, 1'b0, 32'hFFFFFF00, 2'b00};
    vt[16] = '{1'b1, 32'hBF000000, 1'b0, 1'b0, 32'h00000000, 2'b01};
    vt[17] = '{1'b0, 32'h80000000, 1'b1, 1'b1, 32'hCF000000, 2'b00};
    vt[18] = '{1'b1, 32'h01000001, 1'b0, 1'b1, 32'h4B800000, 2'b01};
    vt[19] = '{1'b0, 32'h01000003, 1'b0, 1'b1, 32'h4B800002, 2'b01};

    // Reset with both requesters pending: no grants while reset is high
    v0 = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready0", {31'b0, r0}, 32'd0);
      chk("rst_ready1", {31'b0, r1}, 32'd0);
    end
    v0 = 1'b0; v1 = 1'b0;
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_id", {31'b0, rsp_id}, 32'd0);
    chk("rst_flags", {30'b0, rsp_flags}, 32'd0);

    // Latency: ready cycle, CONV cycle, then response
    @(posedge clk); #1;
    set_req(1'b0, 32'h4048F5C3, 1'b0, 1'b0, 32'h00000003, 2'b01);
    wait_grant(1'b0, "lat");
    @(posedge clk); #1 v0 = 1'b0;
    @(negedge clk);
    chk("lat_conv_valid", {31'b0, rsp_valid}, 32'd0);
    chk("lat_conv_ready0", {31'b0, r0}, 32'd0);
    @(negedge clk);
    chk("lat_resp_valid", {31'b0, rsp_valid}, 32'd1);
    wait_drain("lat");

    foreach (vt[i]) do_op(vt[i]);

    // Round robin from reset priority 0
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    sb.delete();
    set_req(1'b0, 32'h00000001, 1'b0, 1'b1, 32'h3F800000, 2'b00);
    set_req(1'b1, 32'h00000064, 1'b1, 1'b1, 32'h42C80000, 2'b00);
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (r0 || r1) begin
        order = {r1, r0};
        chk("rr_grant", {30'b0, order}, (n % 2 == 0) ? 32'd1 : 32'd2);
        n++;
      end
    end
    if (n < 4) chk("rr_grant_count", n, 32'd4);
    @(posedge clk); #1 v0 = 1'b0; v1 = 1'b0;
    wait_drain("rr");

    // Backpressure: response held, other requester starved until handshake
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_req(1'b1, 32'h4048F5C3, 1'b0, 1'b0, 32'h00000003, 2'b01);
    wait_grant(1'b1, "bp");
    @(posedge clk); #1 v1 = 1'b0;
    set_req(1'b0, 32'h3F800000, 1'b1, 1'b0, 32'h00000001, 2'b00);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_data", rsp_data, 32'h00000003);
      chk("bp_flags", {30'b0, rsp_flags}, 32'd1);
      chk("bp_no_grant", {30'b0, r1, r0}, 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_ready0", {31'b0, r0}, 32'd0);
    @(negedge clk);
    chk("bp_resume_ready0", {31'b0, r0}, 32'd1);
    @(posedge clk); #1 v0 = 1'b0;
    wait_drain("bp");

    // Reset during CONV aborts the operation
    @(posedge clk); #1;
    set_req(1'b0, 32'h00000064, 1'b0, 1'b1, 32'h42C80000, 2'b00);
    wait_grant(1'b0, "rc");
    @(posedge clk); #1 v0 = 1'b0; rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rc_no_valid", {31'b0, rsp_valid}, 32'd0);
    end
    chk("rc_data", rsp_data, 32'd0);
    do_op('{1'b1, 32'h4048F5C3, 1'b1, 1'b0, 32'h00000003, 2'b01});

    chk("sb_empty_end", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout want completion");
    $fatal(1);
  end

endmodule
